// File: rtl/fx2_fifo_reader.sv
// FX2 slave-FIFO reader: pulls 16-bit words from one OUT endpoint and presents them
// on a valid/ready stream through a small first-word-fall-through FIFO.
module fx2_fifo_reader #(
    parameter logic [1:0] EP_ADDR      = 2'b01,
    parameter int         DEPTH        = 4,
    parameter int         SETUP_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic        flag_ne_i,
    input  logic [15:0] fd_i,
    output logic        slrd_o,
    output logic        sloe_o,
    output logic [1:0]  fifoaddr_o,
    output logic [15:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [15:0] words_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, SETUP, ARM, READ, GAP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  setup_cnt_q, setup_cnt_d;
    logic        slrd_q, slrd_d;
    logic        sloe_q, sloe_d;
    logic [1:0]  fifoaddr_q, fifoaddr_d;
    logic        valid_q, valid_d;
    logic [15:0] words_q, words_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] mem_q [DEPTH];
    logic [15:0] mem_d [DEPTH];

    logic push, pop, full, can_launch;

    assign push       = (state_q == READ);
    assign pop        = valid_q && ready_i;
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle is not counted on to free the slot.
    assign can_launch = flag_ne_i && !full;

    // GAP evaluates the ARM launch condition itself so back-to-back words run at 1 per 2 clocks.
    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d     = SETUP;
                    setup_cnt_d = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (!enable_i)                 state_d = IDLE;
                else if (setup_cnt_q == 4'd0)  state_d = ARM;
                else                           setup_cnt_d = setup_cnt_q - 4'd1;
            end
            ARM: begin
                if (!enable_i)       state_d = IDLE;
                else if (can_launch) state_d = READ;
            end
            READ: state_d = GAP;
            GAP: begin
                if (!enable_i)       state_d = IDLE;
                else if (can_launch) state_d = READ;
                else                 state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slrd_d     = (state_d == READ);
        sloe_d     = (state_d != IDLE);
        fifoaddr_d = EP_ADDR;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        words_d    = words_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = fd_i;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            words_d  = words_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        valid_d = (wr_ptr_d != rd_ptr_d);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            setup_cnt_q <= 4'd0;
            slrd_q      <= 1'b0;
            sloe_q      <= 1'b0;
            fifoaddr_q  <= EP_ADDR;
            valid_q     <= 1'b0;
            words_q     <= 16'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'd0;
            end
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            slrd_q      <= slrd_d;
            sloe_q      <= sloe_d;
            fifoaddr_q  <= fifoaddr_d;
            valid_q     <= valid_d;
            words_q     <= words_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
        end
    end

    assign slrd_o     = slrd_q;
    assign sloe_o     = sloe_q;
    assign fifoaddr_o = fifoaddr_q;
    assign valid_o    = valid_q;
    assign words_o    = words_q;
    assign data_o     = mem_q[rd_ptr_q[AW-1:0]];

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(push && full));
    a_no_back_to_back_slrd: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(slrd_q && slrd_d));
    a_slrd_needs_sloe: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(slrd_q && !sloe_q));
endmodule

// File: tb/tb_fx2_fifo_reader.sv
// Self-checking bench for fx2_fifo_reader: an FX2 endpoint model feeds random words and a
// scoreboard checks the delivered stream, pulse timing, counters and reset behaviour.
module tb_fx2_fifo_reader;
    localparam logic [1:0] EP_ADDR      = 2'b01;
    localparam int         DEPTH        = 4;
    localparam int         SETUP_CYCLES = 2;

    logic        clk_i     = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        enable_i  = 1'b0;
    logic        flag_ne_i = 1'b0;
    logic [15:0] fd_i      = 16'h0;
    logic        ready_i   = 1'b0;
    logic        slrd_o, sloe_o, valid_o;
    logic [1:0]  fifoaddr_o;
    logic [15:0] data_o, words_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Endpoint contents, words taken from it but not yet delivered, and activity counters.
    logic [15:0] fx2_q[$];
    logic [15:0] exp_q[$];
    int          pulse_cycles[$];
    logic        fx2_pending = 1'b0;
    logic        prev_slrd   = 1'b0;
    logic [15:0] words_model = 16'd0;
    int          pulses      = 0;
    int          delivered   = 0;
    int          cycle       = 0;

    fx2_fifo_reader #(
        .EP_ADDR(EP_ADDR), .DEPTH(DEPTH), .SETUP_CYCLES(SETUP_CYCLES)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .flag_ne_i(flag_ne_i),
        .fd_i(fd_i), .slrd_o(slrd_o), .sloe_o(sloe_o), .fifoaddr_o(fifoaddr_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .words_o(words_o)
    );

    always #5 clk_i = ~clk_i;

    // The endpoint gives up its head word on the edge that samples SLRD high; the flag
    // and FD reflect that by the middle of the following cycle.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            prev_slrd = 1'b0;
        end else begin
            cycle++;
            n_checks++;
            if (slrd_o && prev_slrd) begin
                n_fail++;
                $display("[TB] FAIL slrd_back_to_back: slrd_o=1 in two consecutive cycles at cycle %0d, required isolated pulses", cycle);
            end
            n_checks++;
            if (slrd_o && !sloe_o) begin
                n_fail++;
                $display("[TB] FAIL slrd_without_sloe: slrd_o=1 with sloe_o=0 at cycle %0d, required sloe_o=1", cycle);
            end
            prev_slrd = slrd_o;
            if (fx2_pending) begin
                fx2_pending = 1'b0;
                n_checks++;
                if (fx2_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL read_empty_endpoint: read with 0 words available, required flag_ne_i=1");
                end else begin
                    exp_q.push_back(fx2_q.pop_front());
                    words_model += 16'd1;
                end
            end
            if (slrd_o) begin
                fx2_pending = 1'b1;
                pulses++;
                pulse_cycles.push_back(cycle);
            end
            if (valid_o && ready_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL stream_extra_word: got %04h, required no word", data_o);
                end else begin
                    if (data_o !== exp_q[0]) begin
                        n_fail++;
                        $display("[TB] FAIL stream_data: got %04h, required %04h", data_o, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                delivered++;
            end
        end
        fd_i      = (fx2_q.size() != 0) ? fx2_q[0] : 16'h0;
        flag_ne_i = (fx2_q.size() != 0);
    end

    task automatic do_reset();
        @(posedge clk_i); #1;
        reset_n_i = 1'b0;
        fx2_q.delete();
        exp_q.delete();
        pulse_cycles.delete();
        fx2_pending = 1'b0;
        words_model = 16'd0;
        pulses      = 0;
        delivered   = 0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) fx2_q.push_back(16'($urandom));
    endtask

    task automatic test_reset();
        int first_sloe = -1;
        int first_slrd = -1;
        @(posedge clk_i); #1;
        reset_n_i = 1'b0;
        enable_i  = 1'b1;
        ready_i   = 1'b1;
        fx2_q.delete(); exp_q.delete(); pulse_cycles.delete();
        fx2_pending = 1'b0; words_model = 16'd0; pulses = 0; delivered = 0;
        load_random(4);
        repeat (2) @(posedge clk_i);
        #1;
        n_checks += 6;
        if (slrd_o !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_slrd: got %b, required 0", slrd_o); end
        if (sloe_o !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_sloe: got %b, required 0", sloe_o); end
        if (fifoaddr_o !== EP_ADDR) begin n_fail++; $display("[TB] FAIL reset_fifoaddr: got %b, required %b", fifoaddr_o, EP_ADDR); end
        if (valid_o !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_valid: got %b, required 0", valid_o); end
        if (data_o !== 16'h0)     begin n_fail++; $display("[TB] FAIL reset_data: got %04h, required 0000", data_o); end
        if (words_o !== 16'h0)    begin n_fail++; $display("[TB] FAIL reset_words: got %04h, required 0000", words_o); end
        reset_n_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_i); #1;
            if (sloe_o && first_sloe < 0) first_sloe = k;
            if (slrd_o && first_slrd < 0) first_slrd = k;
        end
        n_checks += 3;
        if (first_sloe != 1) begin n_fail++; $display("[TB] FAIL sloe_rise: got clk %0d after release, required 1", first_sloe); end
        if (first_slrd != first_sloe + SETUP_CYCLES + 1) begin
            n_fail++; $display("[TB] FAIL first_slrd: got clk %0d, required %0d", first_slrd, first_sloe + SETUP_CYCLES + 1);
        end
        if (fifoaddr_o !== EP_ADDR) begin n_fail++; $display("[TB] FAIL run_fifoaddr: got %b, required %b", fifoaddr_o, EP_ADDR); end
    endtask

    task automatic test_stream();
        enable_i = 1'b0;
        ready_i  = 1'b1;
        do_reset();
        for (int i = 1; i <= 8; i++) fx2_q.push_back(16'(i));
        enable_i = 1'b1;
        for (int t = 0; t < 100 && delivered < 8; t++) @(posedge clk_i);
        #1;
        n_checks += 3;
        if (delivered != 8)  begin n_fail++; $display("[TB] FAIL stream_count: got %0d words, required 8", delivered); end
        if (words_o !== 16'd8) begin n_fail++; $display("[TB] FAIL stream_words: got %0d, required 8", words_o); end
        if (pulses != 8)     begin n_fail++; $display("[TB] FAIL stream_pulses: got %0d, required 8", pulses); end
        for (int i = 1; i < pulse_cycles.size(); i++) begin
            n_checks++;
            if (pulse_cycles[i] - pulse_cycles[i-1] != 2) begin
                n_fail++;
                $display("[TB] FAIL stream_rate: got pulse spacing %0d, required 2", pulse_cycles[i] - pulse_cycles[i-1]);
            end
        end
        repeat (10) @(posedge clk_i);
        #1;
        n_checks++;
        if (pulses != 8) begin n_fail++; $display("[TB] FAIL stream_idle: got %0d pulses after flag low, required 8", pulses); end
    endtask

    task automatic test_backpressure();
        enable_i = 1'b0;
        ready_i  = 1'b0;
        do_reset();
        load_random(10);
        enable_i = 1'b1;
        repeat (40) @(posedge clk_i);
        #1;
        n_checks += 3;
        if (pulses != DEPTH)   begin n_fail++; $display("[TB] FAIL bp_pulses: got %0d, required %0d", pulses, DEPTH); end
        if (valid_o !== 1'b1)  begin n_fail++; $display("[TB] FAIL bp_valid: got %b, required 1", valid_o); end
        if (words_o !== 16'(DEPTH)) begin n_fail++; $display("[TB] FAIL bp_words: got %0d, required %0d", words_o, DEPTH); end
        ready_i = 1'b1;
        for (int t = 0; t < 200 && delivered < 10; t++) @(posedge clk_i);
        #1;
        n_checks += 4;
        if (delivered != 10)   begin n_fail++; $display("[TB] FAIL bp_delivered: got %0d, required 10", delivered); end
        if (pulses != 10)      begin n_fail++; $display("[TB] FAIL bp_total_pulses: got %0d, required 10", pulses); end
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL bp_lost: got %0d undelivered, required 0", exp_q.size()); end
        if (words_o !== words_model) begin n_fail++; $display("[TB] FAIL bp_words_final: got %0d, required %0d", words_o, words_model); end
    endtask

    task automatic test_enable_drop();
        bit seen = 1'b0;
        enable_i = 1'b0;
        ready_i  = 1'b1;
        do_reset();
        load_random(5);
        enable_i = 1'b1;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(posedge clk_i); #1;
            seen = slrd_o;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("[TB] FAIL drop_timeout: got no slrd_o in 20 clks, required a pulse"); end
        enable_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++;
        if (sloe_o !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_sloe_gap: got %b, required 1", sloe_o); end
        @(posedge clk_i); #1;
        n_checks++;
        if (sloe_o !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_sloe_fall: got %b, required 0", sloe_o); end
        repeat (10) @(posedge clk_i);
        #1;
        n_checks += 3;
        if (pulses != 1)      begin n_fail++; $display("[TB] FAIL drop_pulses: got %0d, required 1", pulses); end
        if (delivered != 1)   begin n_fail++; $display("[TB] FAIL drop_kept: got %0d words, required 1", delivered); end
        if (words_o !== 16'd1) begin n_fail++; $display("[TB] FAIL drop_words: got %0d, required 1", words_o); end
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        enable_i = 1'b0;
        ready_i  = 1'b0;
        do_reset();
        load_random(6);
        enable_i = 1'b1;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(posedge clk_i); #1;
            seen = slrd_o && (pulses >= 1);
        end
        n_checks += 2;
        if (!seen) begin n_fail++; $display("[TB] FAIL areset_timeout: got no second read, required one"); end
        if (valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_pre_valid: got %b, required 1", valid_o); end
        #2;
        reset_n_i = 1'b0;
        #1;
        n_checks += 4;
        if (slrd_o !== 1'b0)   begin n_fail++; $display("[TB] FAIL areset_slrd: got %b, required 0", slrd_o); end
        if (sloe_o !== 1'b0)   begin n_fail++; $display("[TB] FAIL areset_sloe: got %b, required 0", sloe_o); end
        if (valid_o !== 1'b0)  begin n_fail++; $display("[TB] FAIL areset_valid: got %b, required 0", valid_o); end
        if (words_o !== 16'd0) begin n_fail++; $display("[TB] FAIL areset_words: got %0d, required 0", words_o); end
        enable_i = 1'b0;
        do_reset();
    endtask

    task automatic test_wrap();
        enable_i = 1'b0;
        ready_i  = 1'b1;
        do_reset();
        @(negedge clk_i);
        force dut.words_q = 16'hfffe;
        @(posedge clk_i); #1;
        release dut.words_q;
        words_model = 16'hfffe;
        load_random(3);
        enable_i = 1'b1;
        for (int t = 0; t < 60 && delivered < 3; t++) @(posedge clk_i);
        #1;
        n_checks += 2;
        if (delivered != 3) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d words, required 3", delivered); end
        if (words_o !== words_model) begin n_fail++; $display("[TB] FAIL wrap_words: got %04h, required %04h", words_o, words_model); end
    endtask

    task automatic test_random_traffic();
        int n;
        enable_i = 1'b0;
        ready_i  = 1'b0;
        do_reset();
        n = $urandom_range(12, 24);
        load_random(n);
        enable_i = 1'b1;
        for (int t = 0; t < 1000 && delivered < n; t++) begin
            @(posedge clk_i); #1;
            ready_i  = ($urandom_range(0, 2) != 0);
            enable_i = ($urandom_range(0, 7) != 0);
        end
        enable_i = 1'b1;
        ready_i  = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        n_checks += 4;
        if (delivered != n)    begin n_fail++; $display("[TB] FAIL rand_delivered: got %0d, required %0d", delivered, n); end
        if (pulses != n)       begin n_fail++; $display("[TB] FAIL rand_pulses: got %0d, required %0d", pulses, n); end
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL rand_lost: got %0d undelivered, required 0", exp_q.size()); end
        if (words_o !== words_model) begin n_fail++; $display("[TB] FAIL rand_words: got %0d, required %0d", words_o, words_model); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_enable_drop();
        test_async_reset();
        test_wrap();
        test_random_traffic();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no end of test within time limit, required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
